// File: rtl/usb_line_pkg.sv
// Shared USB line definitions: J/K/SE0 line states with their {DP,DM} encodings,
// the DPDM FSM state type and default EOP timing.
package usb_line_pkg;

    // Enumerator value is the {DP, DM} pin pair for that line state.
    typedef enum logic [1:0] {
        LineSe0 = 2'b00,
        LineK   = 2'b01,
        LineJ   = 2'b10
    } line_e;

    typedef logic [2:0] dpdm_state_t;

    localparam dpdm_state_t StIdle   = 3'd0;
    localparam dpdm_state_t StSend   = 3'd1;
    localparam dpdm_state_t StPh     = 3'd2;
    localparam dpdm_state_t StEopSe0 = 3'd3;
    localparam dpdm_state_t StEopJ   = 3'd4;

    localparam int unsigned EopSe0CyclesDef = 2;
    localparam int unsigned EopJCyclesDef   = 1;

    function automatic logic [1:0] line_pins(input line_e line);
        return line;
    endfunction

    // Line level 1 is J (DP high), level 0 is K.
    function automatic logic [1:0] level_pins(input logic level);
        return level ? line_pins(LineJ) : line_pins(LineK);
    endfunction

    function automatic int unsigned eop_cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI stage: a 0 bit toggles the line level, a 1 bit holds it. The level reloads J (1)
// whenever no packet is being sent so each packet starts from J.
module nrzi_encoder (
    input  logic clock,
    input  logic reset,
    input  logic in_bit,
    input  logic bs_sending,
    output logic nrzi_level,
    output logic nrzi_sending
);

    logic level_d, level_q;
    logic sending_d, sending_q;

    always_comb begin
        level_d   = 1'b1;
        sending_d = bs_sending;
        if (bs_sending) begin
            level_d = in_bit ? level_q : ~level_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q   <= 1'b1;
            sending_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            sending_q <= sending_d;
        end
    end

    assign nrzi_level   = level_q;
    assign nrzi_sending = sending_q;

endmodule

// File: rtl/nrzi_dpdm_encode.sv
// USB transmit back end: NRZI stage plus registered D+/D- drive FSM with automatic EOP.
// Build option: define DPDM_PH_PATH_EN to enable the raw protocol-handler (ph_*) line path.
module nrzi_dpdm_encode
    import usb_line_pkg::*;
#(
    parameter int unsigned EOP_SE0_CYCLES = EopSe0CyclesDef,
    parameter int unsigned EOP_J_CYCLES   = EopJCyclesDef
) (
    input  logic clock,
    input  logic reset,
    input  logic in_bit,
    input  logic bs_sending,
    input  logic ph_in_bit,
    input  logic ph_sending,
    output logic nrzi_sending,
    output logic DP,
    output logic DM,
    output logic out_done
);

    localparam int unsigned CntW = eop_cnt_width(EOP_SE0_CYCLES, EOP_J_CYCLES);
    localparam logic [CntW-1:0] Se0Last = CntW'(EOP_SE0_CYCLES - 1);
    localparam logic [CntW-1:0] JLast   = CntW'(EOP_J_CYCLES - 1);

    logic nrzi_level;

    dpdm_state_t     state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [1:0]      pins_d, pins_q;
    logic            done_d, done_q;

    nrzi_encoder u_nrzi (
        .clock        (clock),
        .reset        (reset),
        .in_bit       (in_bit),
        .bs_sending   (bs_sending),
        .nrzi_level   (nrzi_level),
        .nrzi_sending (nrzi_sending)
    );

`ifndef DPDM_PH_PATH_EN
    logic unused_ph;
    assign unused_ph = ph_in_bit ^ ph_sending;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pins_d  = pins_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                pins_d = line_pins(LineJ);
                if (nrzi_sending) begin
                    state_d = StSend;
                    pins_d  = level_pins(nrzi_level);
                end
`ifdef DPDM_PH_PATH_EN
                else if (ph_sending) begin
                    state_d = StPh;
                    pins_d  = level_pins(ph_in_bit);
                end
`endif
            end
            StSend: begin
                if (nrzi_sending) begin
                    pins_d = level_pins(nrzi_level);
                end else begin
                    state_d = StEopSe0;
                    cnt_d   = '0;
                    pins_d  = line_pins(LineSe0);
                end
            end
`ifdef DPDM_PH_PATH_EN
            StPh: begin
                if (ph_sending) begin
                    pins_d = level_pins(ph_in_bit);
                end else begin
                    state_d = StEopSe0;
                    cnt_d   = '0;
                    pins_d  = line_pins(LineSe0);
                end
            end
`endif
            StEopSe0: begin
                pins_d = line_pins(LineSe0);
                if (cnt_q == Se0Last) begin
                    state_d = StEopJ;
                    cnt_d   = '0;
                    pins_d  = line_pins(LineJ);
                    done_d  = (JLast == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEopJ: begin
                pins_d = line_pins(LineJ);
                if (cnt_q == JLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    // Flag is registered, so raise it on entry to the last J cycle.
                    done_d = (cnt_d == JLast);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                pins_d  = line_pins(LineJ);
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pins_q  <= line_pins(LineJ);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
            done_q  <= done_d;
        end
    end

    assign DP       = pins_q[1];
    assign DM       = pins_q[0];
    assign out_done = done_q;

endmodule

// File: tb/tb_nrzi_dpdm_encode.sv
// Directed bench for nrzi_dpdm_encode: reset, NRZI data, EOP timing, back-to-back, PH path.
module tb_nrzi_dpdm_encode;

    logic clock = 1'b0;
    logic reset;
    logic in_bit;
    logic bs_sending;
    logic ph_in_bit;
    logic ph_sending;
    logic nrzi_sending;
    logic DP;
    logic DM;
    logic out_done;

    int n_tests = 0;
    int n_fail  = 0;
    int dm_bad;
    logic dp_cap [0:127];

    nrzi_dpdm_encode dut (
        .clock        (clock),
        .reset        (reset),
        .in_bit       (in_bit),
        .bs_sending   (bs_sending),
        .ph_in_bit    (ph_in_bit),
        .ph_sending   (ph_sending),
        .nrzi_sending (nrzi_sending),
        .DP           (DP),
        .DM           (DM),
        .out_done     (out_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input int k);
        dp_cap[k] = DP;
        if (DM !== ~DP) dm_bad++;
    endtask

    // Returns one tick after the last data bit leaves DP, i.e. in the first SE0 cycle.
    task automatic send_packet(input logic [127:0] data, input int n);
        dm_bad = 0;
        for (int i = 0; i < n; i++) begin
            bs_sending = 1'b1;
            in_bit     = data[i];
            tick();
            if (i >= 1) capture(i - 1);
        end
        bs_sending = 1'b0;
        in_bit     = 1'b0;
        tick();
        capture(n - 1);
        tick();
    endtask

    // Expects to be called in the first SE0 cycle; {DP,DM,out_done}.
    task automatic check_eop(input string tag);
        check_eq({tag, "_se0a"}, {29'd0, DP, DM, out_done}, 32'b000);
        tick();
        check_eq({tag, "_se0b"}, {29'd0, DP, DM, out_done}, 32'b000);
        tick();
        check_eq({tag, "_jdone"}, {29'd0, DP, DM, out_done}, 32'b101);
        tick();
        check_eq({tag, "_idle"}, {29'd0, DP, DM, out_done}, 32'b100);
    endtask

    initial begin
        logic [87:0] pkt;
        logic        lvl;
        int          mis;

        reset      = 1'b1;
        in_bit     = 1'b0;
        bs_sending = 1'b0;
        ph_in_bit  = 1'b0;
        ph_sending = 1'b0;
        tick();
        tick();
        check_eq("rst_hold", {28'd0, DP, DM, out_done, nrzi_sending}, 32'b1000);
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_idle", {28'd0, DP, DM, out_done, nrzi_sending}, 32'b1000);

        // Full packet: first byte C3 gives DP 1,1,0,1,0,1,1,1.
        pkt = 88'h544a_40aa11b7682df6d8_C3;
        send_packet(128'(pkt), 88);
        check_eq("pkt_first8", {24'd0, dp_cap[0], dp_cap[1], dp_cap[2], dp_cap[3],
                                dp_cap[4], dp_cap[5], dp_cap[6], dp_cap[7]}, 32'b11010111);
        lvl = 1'b1;
        mis = 0;
        for (int i = 0; i < 88; i++) begin
            if (!pkt[i]) lvl = ~lvl;
            if (dp_cap[i] !== lvl) mis++;
        end
        check_eq("pkt_nrzi_all", mis, 0);
        check_eq("pkt_dm_inv", dm_bad, 0);
        check_eop("pkt");

        // 1-bit packet, then bs_sending pulsed during SE0 must be ignored.
        send_packet(128'b0, 1);
        check_eq("one_bit_dp", {31'd0, dp_cap[0]}, 32'd0);
        check_eq("one_bit_se0a", {29'd0, DP, DM, out_done}, 32'b000);
        bs_sending = 1'b1;
        in_bit     = 1'b0;
        tick();
        bs_sending = 1'b0;
        check_eq("b2b_se0b", {29'd0, DP, DM, out_done}, 32'b000);
        tick();
        check_eq("b2b_jdone", {29'd0, DP, DM, out_done}, 32'b101);
        tick();
        check_eq("b2b_idle", {29'd0, DP, DM, out_done}, 32'b100);
        tick();
        check_eq("b2b_idle2", {29'd0, DP, DM, out_done}, 32'b100);

        // Bits 0,0,1,1 after out_done: DP 0,1,1,1 starting from J.
        send_packet(128'b1100, 4);
        check_eq("basic_dp", {28'd0, dp_cap[0], dp_cap[1], dp_cap[2], dp_cap[3]}, 32'b0111);
        check_eq("basic_dm_inv", dm_bad, 0);
        check_eop("basic");

        // nrzi_sending and ph_sending rise together: NRZI data (K) must win.
        bs_sending = 1'b1;
        in_bit     = 1'b0;
        tick();
        in_bit     = 1'b1;
        ph_sending = 1'b1;
        ph_in_bit  = 1'b1;
        tick();
        check_eq("prio_first", {30'd0, DP, DM}, 32'b01);
        bs_sending = 1'b0;
        tick();
        check_eq("prio_second", {30'd0, DP, DM}, 32'b01);
        ph_sending = 1'b0;
        ph_in_bit  = 1'b0;
        tick();
        check_eop("prio");

`ifdef DPDM_PH_PATH_EN
        ph_sending = 1'b1;
        ph_in_bit  = 1'b1;
        tick();
        check_eq("ph_bit1", {30'd0, DP, DM}, 32'b10);
        ph_in_bit = 1'b0;
        tick();
        check_eq("ph_bit0", {30'd0, DP, DM}, 32'b01);
        ph_sending = 1'b0;
        tick();
        check_eop("ph");
`else
        ph_sending = 1'b1;
        ph_in_bit  = 1'b0;
        tick();
        tick();
        check_eq("noph_idle", {29'd0, DP, DM, out_done}, 32'b100);
        ph_sending = 1'b0;
        tick();
`endif

        // Reset mid-packet: immediate return to J, no EOP afterwards.
        bs_sending = 1'b1;
        in_bit     = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("rst_pre", {30'd0, DP, DM}, 32'b01);
        #2;
        reset      = 1'b1;
        bs_sending = 1'b0;
        #1;
        check_eq("rst_async", {28'd0, DP, DM, out_done, nrzi_sending}, 32'b1000);
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_post_a", {29'd0, DP, DM, out_done}, 32'b100);
        tick();
        tick();
        check_eq("rst_post_b", {29'd0, DP, DM, out_done}, 32'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
